// File: rtl/z3_slave_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : z3_slave_ctrl_if
// Brief  : Zorro III bus-side strobes and slave responses for z3_slave_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface z3_slave_ctrl_if;
   logic       FCS_n;
   logic       MTCR_n;
   logic       BERR_n;
   logic [3:0] DS_n;
   logic       READ;
   logic       DOE;
   logic [2:0] FC;
   logic [7:0] ADDR_HI;
   logic       SLAVE_n;
   logic       DTACK_n;
   logic       MTACK_n;
   logic       bus_oe;
   logic       BUFOE_n;
   logic       BUFDIR;

   modport slave (
      input  FCS_n, MTCR_n, BERR_n, DS_n, READ, DOE, FC, ADDR_HI,
      output SLAVE_n, DTACK_n, MTACK_n, bus_oe, BUFOE_n, BUFDIR
   );

   modport master (
      output FCS_n, MTCR_n, BERR_n, DS_n, READ, DOE, FC, ADDR_HI,
      input  SLAVE_n, DTACK_n, MTACK_n, bus_oe, BUFOE_n, BUFDIR
   );
endinterface

`default_nettype wire

// File: rtl/z3_slave_ctrl.sv
//------------------------------------------------------------------------------
// Module : z3_slave_ctrl
// Brief  : Zorro III multi-bank slave cycle sequencer; burst mode when
//          Z3_MULTI_XFER_EN is defined.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module z3_slave_ctrl #(
   parameter int NUM_BANKS      = 2,
   parameter int MATCH_BITS     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic                   CLK,
   input  wire logic                   RST,
   z3_slave_ctrl_if.slave              bus,
   input  wire logic [8*NUM_BANKS-1:0] base_addr,
   input  wire logic [NUM_BANKS-1:0]   bank_en,
   input  wire logic [NUM_BANKS-1:0]   target_ack,
   output logic      [NUM_BANKS-1:0]   bank_sel,
   output logic                        cycle_req,
   output logic                        cycle_abort,
   output logic                        timeout
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_ACK     = 3'd3,
      S_MT_WAIT = 3'd4,
      S_ABORT   = 3'd5
   } state_t;

   localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [6:0]           sync1_q, sync2_q;
   logic [7:0]           cnt_q, cnt_d;
   logic [NUM_BANKS-1:0] bank_sel_q, bank_sel_d;
   logic                 req_q, req_d;
   logic                 abort_q, abort_d;
   logic                 tmo_q, tmo_d;
   logic                 slave_n_q, slave_n_d;
   logic                 dtack_n_q, dtack_n_d;
   logic                 mtack_n_q, mtack_n_d;
   logic                 bufoe_n_q, bufoe_n_d;
   logic                 bufdir_q, bufdir_d;
   logic                 bus_oe_q, bus_oe_d;

   logic                 fcs_s, mtcr_s, berr_s;
   logic [3:0]           ds_s;
   logic [NUM_BANKS-1:0] hit_vec, hit_oh;
   logic                 valid_space, sel_ack;
   logic                 unused_ok;

   assign {fcs_s, mtcr_s, berr_s, ds_s} = sync2_q;

   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_hit
      assign hit_vec[gi] = bank_en[gi] &&
         (bus.ADDR_HI[7 -: MATCH_BITS] == base_addr[8*gi+7 -: MATCH_BITS]);
   end

   // Isolate the lowest set bit so the lowest-numbered bank wins overlaps.
   assign hit_oh      = hit_vec & (~hit_vec + NUM_BANKS'(1));
   assign valid_space = bus.FC[1] ^ bus.FC[0];
   assign sel_ack     = |(target_ack & bank_sel_q);
   assign unused_ok   = ^{base_addr, bus.FC[2], mtcr_s};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = 1'b0;
      abort_d = 1'b0;
      tmo_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fcs_s && (|hit_oh) && valid_space) state_d = S_START;
         end
         S_START: begin
            if (fcs_s) begin
               state_d = S_IDLE;
            end else if (!berr_s) begin
               state_d = S_ABORT;
               abort_d = 1'b1;
            end else if (bus.READ || (!(&ds_s) && bus.DOE)) begin
               state_d = S_DATA;
               req_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            if (fcs_s) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else if (!berr_s) begin
               state_d = S_ABORT;
               abort_d = 1'b1;
            end else if (sel_ack) begin
               state_d = S_ACK;
            end else if (cnt_q == c_tmo_last) begin
               state_d = S_ABORT;
               abort_d = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_ACK: begin
            if (fcs_s) begin
               state_d = S_IDLE;
            end else if (!berr_s) begin
               state_d = S_ABORT;
               abort_d = 1'b1;
            end
`ifdef Z3_MULTI_XFER_EN
            else if ((&ds_s) && mtcr_s) begin
               state_d = S_MT_WAIT;
            end
`endif
         end
         S_MT_WAIT: begin
            if (fcs_s) begin
               state_d = S_IDLE;
            end else if (!berr_s) begin
               state_d = S_ABORT;
               abort_d = 1'b1;
            end else if (!mtcr_s) begin
               state_d = S_START;
            end
         end
         S_ABORT: begin
            if (fcs_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they change on the decision edge.
      slave_n_d = (state_d == S_IDLE);
      bus_oe_d  = (state_d != S_IDLE);
      dtack_n_d = (state_d != S_ACK);
      bufoe_n_d = !(((state_d == S_DATA) || (state_d == S_ACK)) && bus.DOE && berr_s);
`ifdef Z3_MULTI_XFER_EN
      mtack_n_d = !((state_d == S_START) || (state_d == S_DATA) ||
                    (state_d == S_ACK)   || (state_d == S_MT_WAIT));
`else
      mtack_n_d = 1'b1;
`endif

      bufdir_d   = bufdir_q;
      bank_sel_d = bank_sel_q;
      if (state_d == S_IDLE) begin
         bank_sel_d = '0;
      end else if (state_q == S_IDLE) begin
         bank_sel_d = hit_oh;
         bufdir_d   = bus.READ;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bank_sel_q <= '0;
         req_q      <= 1'b0;
         abort_q    <= 1'b0;
         tmo_q      <= 1'b0;
         slave_n_q  <= 1'b1;
         dtack_n_q  <= 1'b1;
         mtack_n_q  <= 1'b1;
         bufoe_n_q  <= 1'b1;
         bufdir_q   <= 1'b0;
         bus_oe_q   <= 1'b0;
      end else begin
         sync1_q    <= {bus.FCS_n, bus.MTCR_n, bus.BERR_n, bus.DS_n};
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bank_sel_q <= bank_sel_d;
         req_q      <= req_d;
         abort_q    <= abort_d;
         tmo_q      <= tmo_d;
         slave_n_q  <= slave_n_d;
         dtack_n_q  <= dtack_n_d;
         mtack_n_q  <= mtack_n_d;
         bufoe_n_q  <= bufoe_n_d;
         bufdir_q   <= bufdir_d;
         bus_oe_q   <= bus_oe_d;
      end
   end

   assign bank_sel    = bank_sel_q;
   assign cycle_req   = req_q;
   assign cycle_abort = abort_q;
   assign timeout     = tmo_q;
   assign bus.SLAVE_n = slave_n_q;
   assign bus.DTACK_n = dtack_n_q;
   assign bus.MTACK_n = mtack_n_q;
   assign bus.bus_oe  = bus_oe_q;
   assign bus.BUFOE_n = bufoe_n_q;
   assign bus.BUFDIR  = bufdir_q;

endmodule

`default_nettype wire

// File: tb/tb_z3_slave_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_z3_slave_ctrl
// Brief  : Self-checking bench for z3_slave_ctrl (honours Z3_MULTI_XFER_EN).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_z3_slave_ctrl;

   localparam int TMO = 8;
`ifdef Z3_MULTI_XFER_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   localparam int P_OFF = 0, P_CLAIM = 1, P_XFER = 2, P_DONE = 3, P_GAP = 4, P_ERR = 5;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] base_addr = 16'h4000;
   logic [1:0]  bank_en = 2'b11;
   logic [1:0]  target_ack = 2'b00;
   logic [1:0]  bank_sel;
   logic        cycle_req, cycle_abort, timeout;

   int n_assert = 0;
   int n_fail   = 0;
   int req_cnt  = 0;
   int dtk_cnt  = 0;
   logic prev_dtack = 1'b1;

   z3_slave_ctrl_if bus ();

   z3_slave_ctrl #(
      .NUM_BANKS     (2),
      .MATCH_BITS    (4),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus),
      .base_addr  (base_addr),
      .bank_en    (bank_en),
      .target_ack (target_ack),
      .bank_sel   (bank_sel),
      .cycle_req  (cycle_req),
      .cycle_abort(cycle_abort),
      .timeout    (timeout)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Reference model: the bus seen through two sample delays, tracked as
   // transfer phases.
   int         mp = P_OFF;
   int         mcnt = 0;
   logic [1:0] msel = 2'b00;
   logic [6:0] hist0 = '1, hist1 = '1, s;
   logic       mf, mm, mb;
   logic [3:0] md;
   logic       e_req = 0, e_abort = 0, e_tmo = 0, e_dir = 0, e_bufoe = 1;
   bit         started = 0;

   function automatic logic [1:0] pick_bank();
      for (int i = 0; i < 2; i++)
         if (bank_en[i] && ((bus.ADDR_HI >> 4) == (base_addr[8*i +: 8] >> 4)))
            return 2'(1 << i);
      return 2'b00;
   endfunction

   always @(posedge CLK) begin
      s     = hist1;
      hist1 = hist0;
      hist0 = {bus.FCS_n, bus.MTCR_n, bus.BERR_n, bus.DS_n};
      {mf, mm, mb, md} = s;
      e_req = 0; e_abort = 0; e_tmo = 0;
      if (RST) begin
         mp = P_OFF; msel = 2'b00; e_dir = 0; mcnt = 0;
         hist0 = '1; hist1 = '1; mb = 1'b1;
      end else if (mp != P_OFF && mf) begin
         if (mp == P_XFER) e_abort = 1;
         mp = P_OFF;
      end else if (mp inside {P_CLAIM, P_XFER, P_DONE, P_GAP} && !mb) begin
         e_abort = 1;
         mp = P_ERR;
      end else begin
         case (mp)
            P_OFF:
               if (!mf && pick_bank() != 2'b00 && (bus.FC[1] != bus.FC[0])) begin
                  mp = P_CLAIM; msel = pick_bank(); e_dir = bus.READ;
               end
            P_CLAIM:
               if (bus.READ || (md != 4'hF && bus.DOE)) begin
                  mp = P_XFER; e_req = 1; mcnt = 0;
               end
            P_XFER:
               if ((target_ack & msel) != 0) mp = P_DONE;
               else begin
                  mcnt++;
                  if (mcnt == TMO) begin mp = P_ERR; e_abort = 1; e_tmo = 1; end
               end
            P_DONE: if (BURST && md == 4'hF && mm) mp = P_GAP;
            P_GAP:  if (!mm) mp = P_CLAIM;
            default: ;
         endcase
      end
      if (mp == P_OFF) msel = 2'b00;
      e_bufoe = !((mp == P_XFER || mp == P_DONE) && bus.DOE && mb);
      started = 1;
   end

   always @(negedge CLK) begin
      if (started) begin
         check("SLAVE_n",     bus.SLAVE_n, mp == P_OFF);
         check("DTACK_n",     bus.DTACK_n, mp != P_DONE);
         check("MTACK_n",     bus.MTACK_n, !(BURST && (mp inside {P_CLAIM, P_XFER, P_DONE, P_GAP})));
         check("bus_oe",      bus.bus_oe, mp != P_OFF);
         check("BUFOE_n",     bus.BUFOE_n, e_bufoe);
         check("BUFDIR",      bus.BUFDIR, e_dir);
         check("bank_sel",    bank_sel, msel);
         check("cycle_req",   cycle_req, e_req);
         check("cycle_abort", cycle_abort, e_abort);
         check("timeout",     timeout, e_tmo);
      end
      if (cycle_req) req_cnt++;
      if (!bus.DTACK_n && prev_dtack) dtk_cnt++;
      prev_dtack = bus.DTACK_n;
   end

   task automatic start_read(input logic [7:0] a, input logic [2:0] fc);
      bus.ADDR_HI = a; bus.FC = fc; bus.READ = 1; bus.DOE = 1;
      bus.DS_n = 4'h0; bus.FCS_n = 0;
   endtask

   task automatic release_bus();
      bus.FCS_n = 1; bus.DS_n = 4'hF; bus.READ = 0; bus.DOE = 0;
      bus.BERR_n = 1; bus.MTCR_n = 1; target_ack = 2'b00;
   endtask

   initial begin
      int r0, d0;
      bus.FCS_n = 1; bus.MTCR_n = 1; bus.BERR_n = 1; bus.DS_n = 4'hF;
      bus.READ = 0; bus.DOE = 0; bus.FC = 3'd0; bus.ADDR_HI = 8'h00;
      tick(3);
      RST = 0;
      check("rst_SLAVE_n", bus.SLAVE_n, 1);
      check("rst_DTACK_n", bus.DTACK_n, 1);
      check("rst_MTACK_n", bus.MTACK_n, 1);
      check("rst_BUFOE_n", bus.BUFOE_n, 1);
      check("rst_bank_sel", bank_sel, 0);
      check("rst_bus_oe", bus.bus_oe, 0);
      tick(2);

      // Single read to bank 1
      start_read(8'h4C, 3'd1);
      tick(1); check("rd_slave_n0", bus.SLAVE_n, 1);
      tick(1); check("rd_slave_n1", bus.SLAVE_n, 1);
      tick(1); check("rd_slave_n2", bus.SLAVE_n, 0);
      check("rd_bank_sel", bank_sel, 2'b10);
      tick(1); check("rd_req", cycle_req, 1);
      check("rd_bufoe", bus.BUFOE_n, 0);
      tick(1); check("rd_req_end", cycle_req, 0);
      target_ack = 2'b10;
      tick(1); check("rd_dtack", bus.DTACK_n, 0);
      release_bus();
      tick(3);
      check("rd_rel_slave", bus.SLAVE_n, 1);
      check("rd_rel_dtack", bus.DTACK_n, 1);
      check("rd_rel_bufoe", bus.BUFOE_n, 1);
      tick(2);

      // Overlapping windows and invalid function codes
      base_addr = 16'h8080;
      bus.ADDR_HI = 8'h8F; bus.FC = 3'd1; bus.FCS_n = 0;
      tick(3); check("ovl_bank_sel", bank_sel, 2'b01);
      release_bus(); tick(4);
      bus.FC = 3'd0; bus.FCS_n = 0;
      tick(4); check("fc0_slave", bus.SLAVE_n, 1);
      release_bus(); tick(4);
      bus.FC = 3'd3; bus.FCS_n = 0;
      tick(4); check("fc3_slave", bus.SLAVE_n, 1);
      release_bus(); tick(4);
      base_addr = 16'h4000;

      // Timeout with no target acknowledge
      start_read(8'h4C, 3'd5);
      tick(4); check("to_req", cycle_req, 1);
      tick(7); check("to_early", timeout, 0);
      tick(1); check("to_pulse", timeout, 1);
      check("to_abort", cycle_abort, 1);
      tick(3); check("to_dtack", bus.DTACK_n, 1);
      check("to_slave_hold", bus.SLAVE_n, 0);
      release_bus(); tick(3);
      check("to_rel", bus.SLAVE_n, 1);
      tick(2);

      // Bus error during DATA; a late acknowledge must be ignored
      start_read(8'h4C, 3'd1);
      tick(4); bus.BERR_n = 0;
      tick(3); check("be_abort", cycle_abort, 1);
      check("be_bufoe", bus.BUFOE_n, 1);
      check("be_slave", bus.SLAVE_n, 0);
      target_ack = 2'b10;
      tick(2); check("be_dtack", bus.DTACK_n, 1);
      release_bus(); tick(3);
      check("be_rel", bus.SLAVE_n, 1);
      tick(2);

      // Four-transfer write burst
      r0 = req_cnt; d0 = dtk_cnt;
      bus.ADDR_HI = 8'h4C; bus.FC = 3'd1; bus.READ = 0; bus.DOE = 1; bus.FCS_n = 0;
      tick(3);
      for (int t = 0; t < 4; t++) begin
         bus.DS_n = 4'h0; bus.MTCR_n = 0;
         tick(4); target_ack = 2'b10;
         tick(3); target_ack = 2'b00; bus.DS_n = 4'hF; bus.MTCR_n = 1;
         check("bst_mtack", bus.MTACK_n, BURST ? 0 : 1);
         tick(3);
      end
      release_bus(); tick(3);
      check("bst_reqs", req_cnt - r0, BURST ? 4 : 1);
      check("bst_dtacks", dtk_cnt - d0, BURST ? 4 : 1);
      tick(2);

      // Reset while acknowledging
      start_read(8'h4C, 3'd1);
      tick(4); target_ack = 2'b10;
      tick(1); check("rs_dtack_pre", bus.DTACK_n, 0);
      RST = 1;
      tick(1); check("rs_slave", bus.SLAVE_n, 1);
      check("rs_dtack", bus.DTACK_n, 1);
      check("rs_bank_sel", bank_sel, 0);
      RST = 0; release_bus();
      tick(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
